// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and one-hot verdict codes.
// No logic; no latency.
// No flow control.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } cmp_state_t;

    // Verdict bit order is {gt, eq, lt}.
    localparam logic [2:0] VERDICT_GT   = 3'b100;
    localparam logic [2:0] VERDICT_EQ   = 3'b010;
    localparam logic [2:0] VERDICT_LT   = 3'b001;
    localparam logic [2:0] VERDICT_NONE = 3'b000;

endpackage

// File: rtl/bit_cmp_cell.sv
// One-bit magnitude compare cell, driven by the MSBs of the operand shift registers.
// Purely combinational, zero latency.
// No flow control.
module bit_cmp_cell (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic eq,
    output logic lt
);

    assign gt = a & ~b;
    assign eq = ~(a ^ b);
    assign lt = ~a & b;

endmodule

// File: rtl/serial_mag_compare.sv
// Bit-serial unsigned A vs B comparator, MSB first; SERIAL_MAG_COMPARE_EARLY_EXIT_EN stops at the first differing bit.
// Latency: W clocks from accept to out_valid (k+1 with early exit, k = MSB-based index of first difference).
// Backpressure: accepts only in IDLE; out_ready low holds DONE and the verdict indefinitely.
module serial_mag_compare
    import serial_cmp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         a_gt_b,
    output logic         a_eq_b,
    output logic         a_lt_b
);

    localparam int CNT_W = $clog2(W + 1);

    cmp_state_t       state_q,   state_d;
    logic [W-1:0]     sh_a_q,    sh_a_d;
    logic [W-1:0]     sh_b_q,    sh_b_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             decided_q, decided_d;
    logic             gt_q,      gt_d;
    logic             lt_q,      lt_d;
    logic [2:0]       verdict_q, verdict_d;

    logic cell_gt, cell_eq, cell_lt;
    logic first_diff;
    logic finish;

    bit_cmp_cell u_cell (
        .a  (sh_a_q[W-1]),
        .b  (sh_b_q[W-1]),
        .gt (cell_gt),
        .eq (cell_eq),
        .lt (cell_lt)
    );

    always_comb begin
        state_d    = state_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
        cnt_d      = cnt_q;
        decided_d  = decided_q;
        gt_d       = gt_q;
        lt_d       = lt_q;
        verdict_d  = verdict_q;
        first_diff = !decided_q && !cell_eq;
        finish     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_RUN;
                    sh_a_d    = a_in;
                    sh_b_d    = b_in;
                    cnt_d     = CNT_W'(W - 1);
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                end
            end
            S_RUN: begin
                // Only the first differing bit decides; later bits just shift through.
                if (first_diff) begin
                    gt_d      = cell_gt;
                    lt_d      = cell_lt;
                    decided_d = 1'b1;
                end
                sh_a_d = sh_a_q << 1;
                sh_b_d = sh_b_q << 1;
`ifdef SERIAL_MAG_COMPARE_EARLY_EXIT_EN
                finish = (cnt_q == '0) || first_diff;
`else
                finish = (cnt_q == '0);
`endif
                cnt_d = finish ? '0 : cnt_q - CNT_W'(1);
                if (finish) begin
                    state_d   = S_DONE;
                    verdict_d = gt_d ? VERDICT_GT : (lt_d ? VERDICT_LT : VERDICT_EQ);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d   = S_IDLE;
                    verdict_d = VERDICT_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            verdict_q <= VERDICT_NONE;
        end else begin
            state_q   <= state_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            verdict_q <= verdict_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign a_gt_b    = verdict_q[2];
    assign a_eq_b    = verdict_q[1];
    assign a_lt_b    = verdict_q[0];

endmodule
